// File: rtl/sram6116_ctrl.sv
// Registered strobe sequencer for a 2K x 8 asynchronous 6116-type SRAM.
// Optional SRAM_BITREV_EN reverses addr[7:0] and data bits at the pins.
module sram6116_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        sram_csb,
  output logic        sram_web,
  output logic        sram_oeb,
  output logic [10:0] sram_a,
  inout  wire  [7:0]  sram_io
);

  localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(W_EFF + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W_EFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [10:0]     a_q, a_d;
  logic [7:0]      wd_q, wd_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            csb_q, csb_d;
  logic            web_q, web_d;
  logic            oeb_q, oeb_d;
  logic            io_oe_q, io_oe_d;
  logic [10:0]     a_pin;
  logic [7:0]      wd_pin;
  logic [7:0]      rd_user;

`ifdef SRAM_BITREV_EN
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign a_pin   = {addr[10:8], rev8(addr[7:0])};
  assign wd_pin  = rev8(wdata);
  assign rd_user = rev8(sram_io);
`else
  assign a_pin   = addr;
  assign wd_pin  = wdata;
  assign rd_user = sram_io;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    a_d      = a_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          we_d    = we;
          a_d     = a_pin;
          wd_d    = wd_pin;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_LOAD;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          if (!we_q) begin
            rdata_d  = rd_user;
            rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are derived from the next state so every pin comes straight off a flop.
    csb_d   = (state_d == S_IDLE);
    web_d   = !((state_d == S_STROBE) && we_d);
    oeb_d   = !(((state_d == S_SETUP) || (state_d == S_STROBE)) && !we_d);
    io_oe_d = (state_d != S_IDLE) && we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      oeb_q    <= 1'b1;
      io_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      oeb_q    <= oeb_d;
      io_oe_q  <= io_oe_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign sram_csb = csb_q;
  assign sram_web = web_q;
  assign sram_oeb = oeb_q;
  assign sram_a   = a_q;
  assign sram_io  = io_oe_q ? wd_q : 8'hzz;

endmodule
